// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM
// stage and a line-wide off-chip memory. Hits are serviced combinationally in
// the request cycle; misses stall the pipeline while the victim line is
// written back (when dirty) and the requested line is refilled.
module dcache_controller #(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = 32 - $clog2(LINES) - $clog2(LINE_BITS / 8)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_req_i,
  input  logic                 p1_mem_read_i,
  input  logic                 p1_mem_write_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WSEL_W = $clog2(LINE_BITS / 32);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILLED
  } state_t;

  state_t state, state_next;

  // Per-line bookkeeping and storage.
  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [LINE_BITS-1:0] data_mem [LINES];

  // Miss context captured on entry so the refill targets a fixed line.
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  // Request address fields.
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [WSEL_W-1:0]   req_wsel;
  logic [WSEL_W+4:0]   req_bit_lo;
  logic                hit;
  logic                miss;
  logic [31:0]         line_word;

  assign req_idx    = p1_addr_i[OFF_W +: IDX_W];
  assign req_tag    = p1_addr_i[31 -: TAG_W];
  assign req_wsel   = p1_addr_i[2 +: WSEL_W];
  assign req_bit_lo = {req_wsel, 5'd0};

  // Loads are implied by a request without a store; byte lane bits are unused.
  logic unused_inputs;
  assign unused_inputs = ^{p1_mem_read_i, p1_addr_i[1:0]};

  assign hit       = p1_req_i & valid[req_idx] & (tag_mem[req_idx] == req_tag);
  assign miss      = p1_req_i & ~hit;
  assign line_word = data_mem[req_idx][req_bit_lo +: 32];

  // State register and miss context capture.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state    <= IDLE;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && miss) begin
        miss_idx <= req_idx;
        miss_tag <= req_tag;
      end
    end
  end

  // Cache arrays: refill on allocate ack, otherwise merge store hits.
  always_ff @(posedge clk_i) begin
    // NOTE: only valid/dirty are reset; tag and data storage stay unreset so
    // they map onto plain RAM, and valid=0 masks their stale contents.
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == ALLOCATE && mem_ack_i) begin
      data_mem[miss_idx] <= mem_data_i;
      tag_mem[miss_idx]  <= miss_tag;
      valid[miss_idx]    <= 1'b1;
      dirty[miss_idx]    <= 1'b0;
    end else if (hit && p1_mem_write_i) begin
      data_mem[req_idx][req_bit_lo +: 32] <= p1_data_i;
      dirty[req_idx]                      <= 1'b1;
    end
  end

  // Next-state decode and all outputs; everything is held at zero in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_next   = state;
    p1_data_o    = '0;
    p1_stall_o   = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;

    case (state)
      IDLE: begin
        if (miss) begin
          state_next = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_mem[miss_idx], miss_idx, {OFF_W{1'b0}}};
        mem_data_o   = data_mem[miss_idx];
        if (mem_ack_i) begin
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag, miss_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          state_next = REFILLED;
        end
      end
      REFILLED: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (!rst_i) begin
      p1_data_o  = line_word;
      p1_stall_o = miss;
    end else begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller. The reference model treats the
// cache as transparent: loads must return the latest value stored to that
// word, write-backs must carry those latest values, and a per-index shadow of
// valid/tag/dirty predicts hit, miss and write-back traffic.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         p1_req_i;
  logic         p1_mem_read_i;
  logic         p1_mem_write_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int checks   = 0;
  int failures = 0;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .p1_req_i       (p1_req_i),
    .p1_mem_read_i  (p1_mem_read_i),
    .p1_mem_write_i (p1_mem_write_i),
    .p1_addr_i      (p1_addr_i),
    .p1_data_i      (p1_data_i),
    .p1_data_o      (p1_data_o),
    .p1_stall_o     (p1_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Off-chip memory contents (line granularity) and the CPU-visible truth.
  logic [255:0] ext_mem [int unsigned];
  logic [31:0]  ref_mem [int unsigned];

  // Shadow of which line each index holds.
  bit          m_valid [32];
  bit          m_dirty [32];
  logic [21:0] m_tag   [32];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] word_addr);
    return (word_addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [255:0] ext_line(input logic [26:0] la);
    logic [255:0] l;
    if (ext_mem.exists(32'(la))) return ext_mem[32'(la)];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({5'd0, la, 3'(w)});
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [255:0] l;
    logic [2:0]   ws;
    if (ref_mem.exists(32'(addr[31:2]))) return ref_mem[32'(addr[31:2])];
    l  = ext_line(addr[31:5]);
    ws = addr[4:2];
    return l[ws*32 +: 32];
  endfunction

  function automatic logic [255:0] ref_line(input logic [26:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word({la, 3'(w), 2'b00});
    return l;
  endfunction

  // One CPU access, serving memory requests with an ack delay in [dlo, dhi].
  // Entered and left just after a falling edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int dlo, input int dhi);
    int           idx;
    logic [21:0]  tg;
    bit           exp_hit, exp_wb;
    logic [31:0]  wb_addr;
    logic [255:0] exp_line;
    int           stall_cyc, en_cyc, ops, d, cyc;
    idx       = int'(addr[9:5]);
    tg        = addr[31:10];
    exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb    = !exp_hit && m_valid[idx] && m_dirty[idx];
    wb_addr   = {m_tag[idx], addr[9:5], 5'd0};
    stall_cyc = 0;
    en_cyc    = 0;
    ops       = 0;
    d         = -1;
    cyc       = 0;

    p1_req_i       = 1'b1;
    p1_mem_read_i  = rd;
    p1_mem_write_i = wr;
    p1_addr_i      = addr;
    p1_data_i      = data;
    #1;
    check("first_cycle_stall", p1_stall_o, !exp_hit);

    while (p1_stall_o) begin
      stall_cyc++;
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
        en_cyc++;
        if (d < 0) d = $urandom_range(dhi, dlo);
        if (d == 0) begin
          mem_ack_i = 1'b1;
          d = -1;
          if (ops == 0 && exp_wb) begin
            exp_line = ref_line(wb_addr[31:5]);
            check("wb_write", mem_write_o, 1'b1);
            check("wb_addr", mem_addr_o, wb_addr);
            check("wb_data", mem_data_o, exp_line);
            ext_mem[32'(wb_addr[31:5])] = exp_line;
          end else begin
            check("alloc_write", mem_write_o, 1'b0);
            check("alloc_addr", mem_addr_o, {addr[31:5], 5'd0});
            mem_data_i = ext_line(addr[31:5]);
          end
          ops++;
        end else begin
          d--;
        end
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      cyc++;
      if (cyc > 300) begin
        checks++;
        failures++;
        $display("FAIL miss_timeout: stall still high after %0d cycles", cyc);
        break;
      end
    end

    if (!exp_hit) begin
      check("miss_stall_cycles", 256'(stall_cyc), 256'(1 + en_cyc));
      check("miss_mem_ops", 256'(ops), 256'(exp_wb ? 2 : 1));
    end
    check("done_mem_enable", mem_enable_o, 1'b0);
    if (rd && !wr) check("load_data", p1_data_o, ref_word(addr));

    if (wr) ref_mem[32'(addr[31:2])] = data;
    m_dirty[idx] = (exp_hit && m_dirty[idx]) || wr;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;

    @(negedge clk_i);
    p1_req_i       = 1'b0;
    p1_mem_read_i  = 1'b0;
    p1_mem_write_i = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    ref_mem.delete();
  endtask

  initial begin
    logic [255:0] seed_line;
    logic [31:0]  addr;
    logic [4:0]   ridx;
    int           op;

    rst_i          = 1'b1;
    p1_req_i       = 1'b0;
    p1_mem_read_i  = 1'b0;
    p1_mem_write_i = 1'b0;
    p1_addr_i      = '0;
    p1_data_i      = '0;
    mem_data_i     = '0;
    mem_ack_i      = 1'b0;
    model_reset();

    // Line 0x40 starts with word0 = 0x1111_1111.
    seed_line        = ext_line(27'h2);
    seed_line[31:0]  = 32'h1111_1111;
    ext_mem[32'h2]   = seed_line;

    repeat (3) @(negedge clk_i);
    #1;
    check("rst_p1_data", p1_data_o, 32'h0);
    check("rst_stall", p1_stall_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check("idle_mem_enable", mem_enable_o, 1'b0);
    check("idle_mem_write", mem_write_o, 1'b0);
    check("idle_mem_addr", mem_addr_o, 32'h0);
    check("idle_mem_data", mem_data_o, 256'h0);

    // Directed walk through the main scenarios.
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 3);
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 2);
    access(1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 0, 2);
    access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 0, 2);
    access(1'b1, 1'b0, 32'h0000_0448, 32'h0, 1, 3);
    access(1'b0, 1'b1, 32'h0000_0844, 32'hCAFE_0001, 0, 2);
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 2);

    // Reset in the middle of an allocate whose ack is withheld.
    p1_req_i      = 1'b1;
    p1_mem_read_i = 1'b1;
    p1_addr_i     = 32'h0000_03E0;
    #1;
    check("abort_first_stall", p1_stall_o, 1'b1);
    @(negedge clk_i);
    #1;
    check("abort_alloc_enable", mem_enable_o, 1'b1);
    check("abort_alloc_write", mem_write_o, 1'b0);
    check("abort_alloc_addr", mem_addr_o, 32'h0000_03E0);
    repeat (10) @(negedge clk_i);
    #1;
    check("abort_alloc_held", mem_enable_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i         = 1'b0;
    p1_req_i      = 1'b0;
    p1_mem_read_i = 1'b0;
    #1;
    check("abort_mem_enable", mem_enable_o, 1'b0);
    check("abort_stall", p1_stall_o, 1'b0);
    model_reset();
    // A stray ack in IDLE must be ignored.
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check("stray_ack_enable", mem_enable_o, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 2);

    // Randomized traffic over a few indices and tags to force conflicts.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       ridx = 5'd0;
        1:       ridx = 5'd2;
        2:       ridx = 5'd5;
        default: ridx = 5'd31;
      endcase
      addr = {20'($urandom_range(0, 3)), 2'b00, ridx, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      access(op != 1, op != 0, addr, $urandom, 0, 4);
      if ($urandom_range(0, 7) == 0) begin
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check("idle_gap_enable", mem_enable_o, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
